// File: rtl/sha_ctrl_pkg.sv
// Shared types and widths for the SHA-256 round sequencer.
package sha_ctrl_pkg;

    localparam int unsigned ROUND_W       = 7;
    localparam int unsigned PASS_W        = 2;
    localparam int unsigned SHA256_ROUNDS = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        ADD,
        DONE
    } sha_ctrl_state_t;

endpackage

// File: rtl/round_idx_counter.sv
// Round index counter: synchronous clear, count enable, wraps to 0 after MAX.
module round_idx_counter
    import sha_ctrl_pkg::*;
#(
    parameter int unsigned W   = ROUND_W,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         at_max_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == MAX) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_max_o = (cnt_q == MAX);

endmodule

// File: rtl/sha_round_ctrl.sv
// SHA-256 compression sequencer: LOAD / ROUND / ADD per pass, DONE held until acked.
// Optional SHA_CTRL_STALL_EN adds a stall input that freezes round progress.
module sha_round_ctrl
    import sha_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = SHA256_ROUNDS,
    parameter int unsigned NUM_PASSES = 3,
    parameter logic [3:0]  IV_MASK    = 4'b0101
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic               done_ack,
`ifdef SHA_CTRL_STALL_EN
    input  logic               stall,
`endif
    output logic               busy,
    output logic               load_blk,
    output logic               load_iv,
    output logic               round_en,
    output logic [ROUND_W-1:0] round_idx,
    output logic               add_dig,
    output logic [PASS_W-1:0]  pass_idx,
    output logic               done
);

    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [PASS_W-1:0]  PASS_LAST  = PASS_W'(NUM_PASSES - 1);

    sha_ctrl_state_t   state_q, state_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              run_c;
    logic              round_last_c;
    logic              cnt_clr_c;
    logic              cnt_en_c;

`ifdef SHA_CTRL_STALL_EN
    assign run_c = ~stall;
`else
    assign run_c = 1'b1;
`endif

    // Index only advances while rounds run; any other state (or abort) parks it at 0.
    assign cnt_clr_c = (state_q != ROUND) || abort;
    assign cnt_en_c  = (state_q == ROUND) && run_c;

    round_idx_counter #(
        .W   (ROUND_W),
        .MAX (ROUND_LAST)
    ) u_round_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .clr_i    (cnt_clr_c),
        .en_i     (cnt_en_c),
        .cnt_o    (round_idx),
        .at_max_o (round_last_c)
    );

    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        busy     = 1'b0;
        load_blk = 1'b0;
        load_iv  = 1'b0;
        round_en = 1'b0;
        add_dig  = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = LOAD;
                    pass_d  = '0;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                load_blk = 1'b1;
                load_iv  = IV_MASK[pass_q];
                state_d  = ROUND;
            end
            ROUND: begin
                busy     = 1'b1;
                round_en = run_c;
                if (run_c && round_last_c) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                busy    = 1'b1;
                add_dig = 1'b1;
                if (pass_q == PASS_LAST) begin
                    state_d = DONE;
                end else begin
                    pass_d  = pass_q + PASS_W'(1);
                    state_d = LOAD;
                end
            end
            DONE: begin
                done = 1'b1;
                if (done_ack) begin
                    state_d = IDLE;
                    pass_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pass_d  = '0;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            pass_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
        end
    end

    assign pass_idx = pass_q;

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Scoreboarded bench for sha_round_ctrl: per-cycle expected trace from a pass/round model.
module tb_sha_round_ctrl;

    localparam int R   = 64;
    localparam int P   = 3;
    localparam int LAT = P * (R + 2);
    localparam logic [3:0] IV_MASK_M = 4'b0101;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       done_ack = 1'b0;
`ifdef SHA_CTRL_STALL_EN
    logic       stall = 1'b0;
`endif
    logic       busy, load_blk, load_iv, round_en, add_dig, done;
    logic [6:0] round_idx;
    logic [1:0] pass_idx;

    always #5 clk = ~clk;

    sha_round_ctrl dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .abort     (abort),
        .done_ack  (done_ack),
`ifdef SHA_CTRL_STALL_EN
        .stall     (stall),
`endif
        .busy      (busy),
        .load_blk  (load_blk),
        .load_iv   (load_iv),
        .round_en  (round_en),
        .round_idx (round_idx),
        .add_dig   (add_dig),
        .pass_idx  (pass_idx),
        .done      (done)
    );

    logic [14:0] act;
    assign act = {busy, load_blk, load_iv, round_en, round_idx, add_dig, pass_idx, done};

    logic [14:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
    endtask

    function automatic logic [14:0] rec(input bit b, input bit lb, input bit liv, input bit ren,
                                        input int ridx, input bit add, input int pidx, input bit dn);
        return {b, lb, liv, ren, 7'(ridx), add, 2'(pidx), dn};
    endfunction

    // Expected visible outputs for one full job, one entry per cycle, ending with the first DONE cycle.
    task automatic push_trace();
        for (int p = 0; p < P; p++) begin
            exp_q.push_back(rec(1, 1, IV_MASK_M[p], 0, 0, 0, p, 0));
            for (int r = 0; r < R; r++) exp_q.push_back(rec(1, 0, 0, 1, r, 0, p, 0));
            exp_q.push_back(rec(1, 0, 0, 0, 0, 1, p, 0));
        end
        exp_q.push_back(rec(0, 0, 0, 0, 0, 0, P - 1, 1));
    endtask

    // Monitor: every active cycle must match the next expected entry; idle cycles show round_idx 0.
    always @(negedge clk) begin
        if (busy || done || load_blk || load_iv || round_en || add_dig) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got 0x%0h with nothing expected at %0t", act, $time);
            end else begin
                chk("trace", 32'(act), 32'(exp_q.pop_front()));
            end
        end else begin
            chk("idle_round_idx", 32'(round_idx), 32'd0);
        end
    end

    // One job: optional abort / reset / stray start at display index n (n=0 is the LOAD cycle).
    task automatic run_job(input int abort_at, input int rst_at, input int poke_at, input int ack_k);
        int n = 0;
        push_trace();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (n < 400) begin
            if (done) break;
            if (n == rst_at) begin
                n_rst = 1'b0;
                exp_q.delete();
                #1;
                chk("async_reset", 32'(act), 32'd0);
                repeat (2) @(posedge clk);
                #1 n_rst = 1'b1;
                return;
            end
            if (n == abort_at) abort = 1'b1;
            if (n == poke_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (abort) begin
                abort = 1'b0;
                exp_q.delete();
                chk("abort_to_idle", 32'(act), 32'd0);
                return;
            end
        end
        chk("done_latency", 32'(n), 32'(LAT));
        if (!done) return;
        for (int i = 0; i < ack_k; i++) begin
            exp_q.push_back(rec(0, 0, 0, 0, 0, 0, P - 1, 1));
            @(posedge clk); #1;
        end
        done_ack = 1'b1;
        @(posedge clk); #1;
        done_ack = 1'b0;
        chk("ack_to_idle", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        #2;
        chk("reset_outputs", 32'(act), 32'd0);
        #19 n_rst = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1 chk("idle_after_reset", 32'(act), 32'd0);

        run_job(-1, -1, -1, 10);
        run_job(R + 2 + 1 + 30, -1, -1, 2);
        run_job(-1, -1, -1, 0);

        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {31'd0, busy}, 32'd0);
        run_job(-1, -1, 40, 1);

        run_job(-1, 2 * (R + 2) + 1 + 10, -1, 0);
        repeat (3) @(posedge clk);
        #1 chk("idle_until_start", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        for (int j = 0; j < 6; j++) begin
            int a, pk;
            a  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LAT - 1)) : -1;
            pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LAT - 1)) : -1;
            run_job(a, -1, pk, int'($urandom_range(0, 5)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end

        repeat (2) @(posedge clk);
        #1 chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
